cp0: RTL and testbench
======================

Name: cp0

Overview:
- Coprocessor-0 exception/interrupt controller for the pipelined CPU.
- Sits downstream of the two timer counters and the external interrupt line, and consumes the 6-bit HWInt vector the top level assembles from them.
- Holds SR, Cause, EPC and PRId. Arbitrates interrupts against M-stage exceptions and raises a one-cycle-decided request that flushes the pipeline and redirects fetch to the handler.
- The CPU accesses registers through mfc0/mtc0 and clears EXL on eret.

Parameters:
- PRID, 32'h2023_0007, read-only value returned for register 15.
- HANDLER_PC, 32'h0000_4180, handler entry address exported on handler_pc.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous active-high reset
- hw_int  in  6  {3'b0, interrupt, TC1_IRQ, TC0_IRQ}; level-sensitive
- cp0_addr  in  5  register number for mfc0/mtc0 (12 SR, 13 Cause, 14 EPC, 15 PRId)
- cp0_we  in  1  mtc0 write enable (M stage)
- cp0_wdata  in  32  mtc0 write data
- cp0_rdata  out  32  combinational read of register cp0_addr; 0 for unmapped addresses
- vpc  in  32  victim PC of the M-stage instruction
- bd_in  in  1  M-stage instruction is in a branch delay slot
- exc_code_in  in  5  M-stage exception code; 0 means none
- eret  in  1  eret in M stage; clears EXL
- req  out  1  exception/interrupt taken this cycle (combinational)
- epc_out  out  32  current EPC, used as the eret target
- handler_pc  out  32  constant HANDLER_PC

Behaviour:
- Register fields:
  - SR: IM[15:10], EXL[1], IE[0]. All other bits read 0.
  - Cause: BD[31], IP[15:10], ExcCode[6:2]. All other bits read 0.
  - EPC: full 32 bits, with bits [1:0] always 0.
- Reset: SR, Cause and EPC all = 0. req forced to 0 during the reset cycle. cp0_rdata follows the reset register values.
- int_req = IE & ~EXL & |(hw_int & IM).
- exc_req = ~EXL & (exc_code_in != 0).
- req = ~reset & (int_req | exc_req). Interrupt has priority over a simultaneous exception.
- Cause.IP <= hw_int every cycle unconditionally, including the cycle req is taken. Not writable by mtc0.
- On req, at the clock edge:
  - EXL <= 1.
  - Cause.BD <= bd_in.
  - Cause.ExcCode <= int_req ? 0 : exc_code_in.
  - EPC <= (bd_in ? vpc - 4 : vpc) with [1:0] cleared. 32-bit wrap-around on the subtraction.
- mtc0 when cp0_we & ~req:
  - addr 12 writes IM, EXL and IE only.
  - addr 14 writes EPC = {cp0_wdata[31:2], 2'b00}.
  - addr 13, 15 and others are ignored.
  - If req is high, the write is discarded, because the instruction is flushed.
- eret when ~req: EXL <= 0.
  - req and eret in the same cycle: req wins and EXL stays/becomes 1.
  - eret and an mtc0 to SR in the same cycle: the eret clear of EXL wins; the other SR fields take the mtc0 values.
- Read-during-write: cp0_rdata shows the old value. Forwarding is handled by the CPU hazard unit.
- Nested events: while EXL = 1, req is suppressed regardless of hw_int or exc_code_in. A pending, still-asserted interrupt fires on the first cycle after EXL clears, provided IE and IM permit it.
- Reset mid-handler: all state is cleared; EXL = 0, IE = 0, so interrupts are masked until software re-enables them.

Decomposition:
- Shared package cp0_pkg holds:
  - register numbers: SR = 12, CAUSE = 13, EPC = 14, PRID = 15.
  - exception codes: INT = 0, ADEL = 4, ADES = 5, SYSCALL = 8, RI = 10, OV = 12.
  - field bit positions for SR and Cause.
- No sub-module. Request arbitration and register update are tightly coupled, so the block stays flat (~150 lines).

Test Plan:
- Reset then read: reset = 1 for 1 cycle → cp0_rdata = 0 for addrs 12/13/14; addr 15 = 32'h2023_0007; req = 0.
- Timer interrupt:
  - Setup: mtc0 SR = 32'h0000_0401 (IM[10] = 1, IE = 1), then hw_int = 6'b000001, vpc = 32'h3010, bd_in = 0.
  - Response: req = 1 same cycle.
  - Next cycle: EPC = 32'h3010, Cause.ExcCode = 0, SR.EXL = 1, req = 0 despite hw_int still high.
- Delay-slot exception: SR.IE = 0, exc_code_in = 12, vpc = 32'h3024, bd_in = 1 → req = 1; then EPC = 32'h3020, Cause = 32'h8000_0030.
- Priority and masking:
  - Interrupt vs exception: IE = 1, IM = 6'b000010, hw_int = 6'b000010 with exc_code_in = 10 → ExcCode = 0.
  - Masked line: with IM = 0, only the exception (ExcCode 10) is taken.
- Conflicts:
  - req with cp0_we to EPC in the same cycle → EPC = vpc, not cp0_wdata.
  - eret with req (EXL = 0) → EXL ends 1.
  - eret alone → EXL = 0, and a held interrupt re-fires on the next cycle.
- mtc0 masking: write 32'hFFFF_FFFF to SR → reads 32'h0000_FC03. Write to Cause → no change. Write 32'h0000_3013 to EPC → reads 32'h0000_3010.

Source files
------------

// File: rtl/cp0_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cp0_pkg
// Brief    : Shared register numbers, exception codes and field positions
//            for the coprocessor-0 exception/interrupt controller.
// Revision : 1.0 - initial release
// ============================================================================
package cp0_pkg;

  // CP0 register numbers as seen by mfc0/mtc0
  localparam logic [4:0] REG_SR    = 5'd12;
  localparam logic [4:0] REG_CAUSE = 5'd13;
  localparam logic [4:0] REG_EPC   = 5'd14;
  localparam logic [4:0] REG_PRID  = 5'd15;

  // Exception codes carried in Cause.ExcCode
  localparam logic [4:0] EXC_INT     = 5'd0;
  localparam logic [4:0] EXC_ADEL    = 5'd4;
  localparam logic [4:0] EXC_ADES    = 5'd5;
  localparam logic [4:0] EXC_SYSCALL = 5'd8;
  localparam logic [4:0] EXC_RI      = 5'd10;
  localparam logic [4:0] EXC_OV      = 5'd12;

  // SR field positions
  localparam int SR_IM_LO = 10;
  localparam int SR_EXL   = 1;
  localparam int SR_IE    = 0;

  // Cause field positions
  localparam int CAUSE_BD     = 31;
  localparam int CAUSE_IP_LO  = 10;
  localparam int CAUSE_EXC_LO = 2;

  // Assemble the architecturally visible SR word; unimplemented bits read 0
  function automatic logic [31:0] sr_word(input logic [5:0] im,
                                          input logic exl,
                                          input logic ie);
    logic [31:0] w;
    w = '0;
    w[SR_IM_LO +: 6] = im;
    w[SR_EXL]        = exl;
    w[SR_IE]         = ie;
    return w;
  endfunction

  // Assemble the architecturally visible Cause word
  function automatic logic [31:0] cause_word(input logic       bd,
                                             input logic [5:0] ip,
                                             input logic [4:0] exc);
    logic [31:0] w;
    w = '0;
    w[CAUSE_BD]             = bd;
    w[CAUSE_IP_LO +: 6]     = ip;
    w[CAUSE_EXC_LO +: 5]    = exc;
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cp0_if.sv
`default_nettype none
// ============================================================================
// Module   : cp0_if
// Brief    : CPU <-> CP0 bus: mfc0/mtc0 access, M-stage exception info,
//            hardware interrupt vector and redirect outputs.
// Revision : 1.0 - initial release
// ============================================================================
interface cp0_if;
  logic [5:0]  hw_int;
  logic [4:0]  cp0_addr;
  logic        cp0_we;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] vpc;
  logic        bd_in;
  logic [4:0]  exc_code_in;
  logic        eret;
  logic        req;
  logic [31:0] epc_out;
  logic [31:0] handler_pc;

  // CPU side
  modport master (
    output hw_int, cp0_addr, cp0_we, cp0_wdata, vpc, bd_in, exc_code_in, eret,
    input  cp0_rdata, req, epc_out, handler_pc
  );

  // CP0 side
  modport slave (
    input  hw_int, cp0_addr, cp0_we, cp0_wdata, vpc, bd_in, exc_code_in, eret,
    output cp0_rdata, req, epc_out, handler_pc
  );
endinterface
`default_nettype wire

// File: rtl/cp0.sv
`default_nettype none
// ============================================================================
// Module   : cp0
// Brief    : Coprocessor-0: SR/Cause/EPC/PRId, interrupt vs exception
//            arbitration and same-cycle pipeline redirect request.
// Revision : 1.0 - initial release
// ============================================================================
module cp0
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID       = 32'h2023_0007,
  parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
  input  logic clk,
  input  logic reset,
  cp0_if.slave bus
);

  logic [5:0]  sr_im;
  logic        sr_exl;
  logic        sr_ie;
  logic        cause_bd;
  logic [5:0]  cause_ip;
  logic [4:0]  cause_exc;
  logic [31:0] epc;

  logic        int_req;
  logic        exc_req;
  logic        req;
  logic [31:0] victim_pc;

  // Request arbitration: interrupts win over a simultaneous exception, and
  // everything is suppressed while the handler runs (EXL) or during reset.
  always_comb begin
    int_req   = sr_ie & ~sr_exl & (|(bus.hw_int & sr_im));
    exc_req   = ~sr_exl & (bus.exc_code_in != EXC_INT);
    req       = ~reset & (int_req | exc_req);
    victim_pc = bus.bd_in ? (bus.vpc - 32'd4) : bus.vpc;
  end

  // Register update: a taken request flushes the M-stage instruction, so its
  // mtc0/eret side effects are dropped; eret is applied after mtc0 so that it
  // wins the EXL bit when both target SR in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      sr_im     <= '0;
      sr_exl    <= 1'b0;
      sr_ie     <= 1'b0;
      cause_bd  <= 1'b0;
      cause_ip  <= '0;
      cause_exc <= '0;
      epc       <= '0;
    end else begin
      cause_ip <= bus.hw_int;
      if (req) begin
        sr_exl    <= 1'b1;
        cause_bd  <= bus.bd_in;
        cause_exc <= int_req ? EXC_INT : bus.exc_code_in;
        epc       <= victim_pc & ~32'd3;
      end else begin
        if (bus.cp0_we && bus.cp0_addr == REG_SR) begin
          sr_im  <= bus.cp0_wdata[SR_IM_LO +: 6];
          sr_exl <= bus.cp0_wdata[SR_EXL];
          sr_ie  <= bus.cp0_wdata[SR_IE];
        end
        if (bus.cp0_we && bus.cp0_addr == REG_EPC) begin
          epc <= bus.cp0_wdata & ~32'd3;
        end
        if (bus.eret) begin
          sr_exl <= 1'b0;
        end
      end
    end
  end

  // Combinational register read; shows pre-write values during an mtc0
  always_comb begin
    bus.cp0_rdata = '0;
    case (bus.cp0_addr)
      REG_SR:    bus.cp0_rdata = sr_word(sr_im, sr_exl, sr_ie);
      REG_CAUSE: bus.cp0_rdata = cause_word(cause_bd, cause_ip, cause_exc);
      REG_EPC:   bus.cp0_rdata = epc;
      REG_PRID:  bus.cp0_rdata = PRID;
      default:   bus.cp0_rdata = '0;
    endcase
  end

  // Redirect outputs
  always_comb begin
    bus.req        = req;
    bus.epc_out    = epc;
    bus.handler_pc = HANDLER_PC;
  end

endmodule
`default_nettype wire

// File: tb/tb_cp0.sv
`default_nettype none
// ============================================================================
// Module   : tb_cp0
// Brief    : Directed testbench for cp0 with a queue-based scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cp0;
  import cp0_pkg::*;

  localparam int SEL_RDATA = 0;
  localparam int SEL_REQ   = 1;
  localparam int SEL_EPC   = 2;
  localparam int SEL_HPC   = 3;

  typedef struct {
    int          cyc;
    int          sel;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  int   cur_cyc = 0;
  int   errors  = 0;
  int   checks  = 0;
  exp_t sb[$];

  cp0_if bus();

  cp0 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Cycle tag used to pair expectations with the cycle they belong to
  always @(posedge clk) cur_cyc <= cur_cyc + 1;

  // Apply one cycle of stimulus just after the active edge
  task automatic step(input logic rst, input logic [5:0] hw, input logic [4:0] addr,
                      input logic we, input logic [31:0] wd, input logic [31:0] pc,
                      input logic bd, input logic [4:0] exc, input logic er);
    @(posedge clk);
    #1;
    reset           = rst;
    bus.hw_int      = hw;
    bus.cp0_addr    = addr;
    bus.cp0_we      = we;
    bus.cp0_wdata   = wd;
    bus.vpc         = pc;
    bus.bd_in       = bd;
    bus.exc_code_in = exc;
    bus.eret        = er;
  endtask

  // Push an expectation for the current cycle
  task automatic expect_val(input int sel, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc  = cur_cyc;
    e.sel  = sel;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: on the falling edge, compare every expectation due this cycle
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].cyc == cur_cyc) begin
      exp_t e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.sel)
        SEL_RDATA: act = bus.cp0_rdata;
        SEL_REQ:   act = {31'b0, bus.req};
        SEL_EPC:   act = bus.epc_out;
        default:   act = bus.handler_pc;
      endcase
      checks = checks + 1;
      if (act !== e.exp) begin
        errors = errors + 1;
        $display("FAIL %s: got %h expected %h (cycle %0d)", e.name, act, e.exp, cur_cyc);
      end
    end
  end

  initial begin
    reset = 1'b1;
    bus.hw_int = '0; bus.cp0_addr = '0; bus.cp0_we = 1'b0; bus.cp0_wdata = '0;
    bus.vpc = '0; bus.bd_in = 1'b0; bus.exc_code_in = '0; bus.eret = 1'b0;

    // Reset: req forced low even with a pending exception code
    step(1, 6'd0, REG_SR, 0, 0, 0, 0, EXC_ADEL, 0);
    step(1, 6'd0, REG_PRID, 0, 0, 0, 0, EXC_ADEL, 0);
    expect_val(SEL_REQ, 32'd0, "req_in_reset");
    expect_val(SEL_RDATA, 32'h2023_0007, "prid_in_reset");

    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "sr_reset");
    expect_val(SEL_REQ, 32'd0, "req_idle");
    expect_val(SEL_HPC, 32'h0000_4180, "handler_pc");
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "cause_reset");
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "epc_reset");
    step(0, 6'd0, REG_PRID, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h2023_0007, "prid_read");

    // Timer interrupt: enable IM[10]/IE; read-during-write shows old SR
    step(0, 6'd0, REG_SR, 1, 32'h0000_0401, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "sr_rdw_old");
    step(0, 6'd1, REG_SR, 0, 0, 32'h3010, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0401, "sr_after_mtc0");
    expect_val(SEL_REQ, 32'd1, "timer_req");
    step(0, 6'd1, REG_EPC, 0, 0, 32'h3010, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_3010, "timer_epc");
    expect_val(SEL_EPC, 32'h0000_3010, "timer_epc_out");
    expect_val(SEL_REQ, 32'd0, "req_masked_exl");
    step(0, 6'd1, REG_CAUSE, 0, 0, 32'h3010, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0400, "timer_cause");
    step(0, 6'd1, REG_SR, 0, 0, 32'h3010, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0403, "timer_sr_exl");

    // eret alone, then the held interrupt fires again
    step(0, 6'd1, REG_SR, 0, 0, 32'h3010, 0, 0, 1);
    expect_val(SEL_REQ, 32'd0, "req_during_eret");
    step(0, 6'd1, REG_SR, 0, 0, 32'h3100, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0401, "sr_after_eret");
    expect_val(SEL_REQ, 32'd1, "int_refire");
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_3100, "refire_epc");

    // eret + mtc0 SR together: eret clears EXL, IM/IE from write data
    step(0, 6'd0, REG_SR, 1, 32'h0000_0402, 0, 0, 0, 1);
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0400, "eret_mtc0_sr");

    // Delay-slot overflow with IE = 0
    step(0, 6'd0, REG_SR, 0, 0, 32'h3024, 1, EXC_OV, 0);
    expect_val(SEL_REQ, 32'd1, "ds_exc_req");
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_3020, "ds_epc");
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h8000_0030, "ds_cause");

    // Interrupt beats a simultaneous RI exception
    step(0, 6'd0, REG_SR, 1, 32'h0000_0801, 0, 0, 0, 1);
    step(0, 6'd2, REG_SR, 0, 0, 32'h3200, 0, EXC_RI, 0);
    expect_val(SEL_REQ, 32'd1, "prio_req");
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0800, "prio_cause_int");

    // Masked line (IM = 0): only the exception is taken
    step(0, 6'd0, REG_SR, 1, 32'h0000_0001, 0, 0, 0, 1);
    step(0, 6'd2, REG_SR, 0, 0, 32'h3300, 0, EXC_RI, 0);
    expect_val(SEL_REQ, 32'd1, "masked_req");
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0828, "masked_cause");

    // req + eret + mtc0 EPC in one cycle: req wins everything
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 1);
    step(0, 6'd0, REG_EPC, 1, 32'h5555_5554, 32'h3400, 0, EXC_ADEL, 1);
    expect_val(SEL_REQ, 32'd1, "conflict_req");
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_3400, "conflict_epc");
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0003, "conflict_exl");

    // mtc0 field masking
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 1);
    step(0, 6'd0, REG_SR, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_FC03, "sr_mask");
    step(0, 6'd0, REG_CAUSE, 1, 32'hFFFF_FFFF, 0, 0, 0, 0);
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_0010, "cause_ro");
    step(0, 6'd0, REG_EPC, 1, 32'h0000_3013, 0, 0, 0, 0);
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0000_3010, "epc_align");
    expect_val(SEL_EPC, 32'h0000_3010, "epc_out_align");

    // EPC wrap-around: delay slot at address 0
    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 1);
    step(0, 6'd0, REG_SR, 0, 0, 32'h0, 1, EXC_ADES, 0);
    expect_val(SEL_REQ, 32'd1, "wrap_req");
    step(0, 6'd0, REG_EPC, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'hFFFF_FFFC, "wrap_epc");
    step(0, 6'd0, REG_CAUSE, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h8000_0014, "wrap_cause");

    // Reset mid-handler clears everything; interrupts stay masked after
    step(1, 6'd1, REG_SR, 0, 0, 0, 0, EXC_SYSCALL, 0);
    expect_val(SEL_REQ, 32'd0, "req_mid_reset");
    step(0, 6'd1, REG_SR, 0, 0, 32'h3500, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "sr_after_reset");
    expect_val(SEL_REQ, 32'd0, "int_masked_after_reset");
    step(0, 6'd1, 5'd3, 0, 0, 0, 0, 0, 0);
    expect_val(SEL_RDATA, 32'h0, "unmapped_read");

    step(0, 6'd0, REG_SR, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    if (sb.size() != 0) begin
      errors = errors + sb.size();
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
